// File: rtl/timer_controller.sv
// Minute/second timer: preset entry, up/down counting with a one-second
// prescaler, pause/resume and optional auto-reload on expiry.
module timer_controller #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned MIN_MAX     = 99,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       dir,
  output logic [5:0] sec,
  output logic [6:0] min,
  output logic [2:0] state,
  output logic       running,
  output logic       expired,
  output logic       tick
);

  localparam int unsigned PW     = $clog2(TICK_DIV);
  localparam int unsigned NBTN   = 5;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    MIN_TOP    = 7'(MIN_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SET     = 3'd1,
    S_RUN     = 3'd2,
    S_PAUSE   = 3'd3,
    S_EXPIRED = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      sec_q, sec_d;
  logic [6:0]      min_q, min_d;
  logic [5:0]      psec_q, psec_d;
  logic [6:0]      pmin_q, pmin_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            dir_q, dir_d;
  logic            tick_q, tick_d;
  logic            running_q, expired_q;
  logic [NBTN-1:0] btn_q;
  logic [NBTN-1:0] btn_now;
  logic [NBTN-1:0] rise;
  logic            ev_clear, ev_stop, ev_start, ev_imin, ev_isec;

  function automatic logic [5:0] sec_inc(input logic [5:0] s);
    return (s == 6'd59) ? 6'd0 : s + 6'd1;
  endfunction

  function automatic logic [6:0] min_inc(input logic [6:0] m);
    return (m == MIN_TOP) ? 7'd0 : m + 7'd1;
  endfunction

  // Button rising edges, reduced to the single highest-priority event
  assign btn_now  = {clear, stop, start, inc_min, inc_sec};
  assign rise     = btn_now & ~btn_q;
  assign ev_clear = rise[4];
  assign ev_stop  = rise[3] & ~rise[4];
  assign ev_start = rise[2] & ~|rise[4:3];
  assign ev_imin  = rise[1] & ~|rise[4:2];
  assign ev_isec  = rise[0] & ~|rise[4:1];

  // Next-state, time and preset update
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    psec_d  = psec_q;
    pmin_d  = pmin_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;

    case (state_q)
      S_IDLE, S_SET: begin
        if (ev_clear) begin
          state_d = S_IDLE;
        end else if (ev_start) begin
          state_d = S_RUN;
          dir_d   = dir;
          presc_d = '0;
          sec_d   = dir ? 6'd0 : psec_q;
          min_d   = dir ? 7'd0 : pmin_q;
        end else if (ev_imin) begin
          state_d = S_SET;
          pmin_d  = min_inc(pmin_q);
          min_d   = min_inc(pmin_q);
          sec_d   = psec_q;
        end else if (ev_isec) begin
          state_d = S_SET;
          psec_d  = sec_inc(psec_q);
          sec_d   = sec_inc(psec_q);
          min_d   = pmin_q;
        end
      end

      S_RUN: begin
        if (ev_clear) begin
          state_d = S_IDLE;
        end else if (ev_stop) begin
          state_d = S_PAUSE;
        end else if (!dir_q && sec_q == 6'd0 && min_q == 7'd0) begin
          // Down-count from 00:00 expires without waiting for a tick
          state_d = S_EXPIRED;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (dir_q) begin
            if (sec_q == 6'd59 && min_q == MIN_TOP) begin
              state_d = S_EXPIRED;
            end else if (sec_q == 6'd59) begin
              sec_d = 6'd0;
              min_d = min_q + 7'd1;
            end else begin
              sec_d = sec_q + 6'd1;
            end
          end else begin
            if (sec_q == 6'd0) begin
              sec_d = 6'd59;
              min_d = min_q - 7'd1;
            end else begin
              sec_d = sec_q - 6'd1;
            end
            if (min_q == 7'd0 && sec_q == 6'd1) begin
              state_d = S_EXPIRED;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      S_PAUSE: begin
        if (ev_clear) begin
          state_d = S_IDLE;
        end else if (ev_start) begin
          state_d = S_RUN;
        end
      end

      S_EXPIRED: begin
        if (ev_clear || ev_stop) begin
          state_d = S_IDLE;
        end else if (AUTO_RELOAD != 0 && !dir_q) begin
          state_d = S_RUN;
          sec_d   = psec_q;
          min_d   = pmin_q;
          presc_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Entering or staying in IDLE wipes display, preset and prescaler
    if (state_d == S_IDLE) begin
      sec_d   = 6'd0;
      min_d   = 7'd0;
      psec_d  = 6'd0;
      pmin_d  = 7'd0;
      presc_d = '0;
    end
  end

  // State, time and status registers; buttons reset high to mask held inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sec_q     <= 6'd0;
      min_q     <= 7'd0;
      psec_q    <= 6'd0;
      pmin_q    <= 7'd0;
      presc_q   <= '0;
      dir_q     <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      btn_q     <= '1;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      psec_q    <= psec_d;
      pmin_q    <= pmin_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      running_q <= (state_d == S_RUN);
      expired_q <= (state_d == S_EXPIRED);
      btn_q     <= btn_now;
    end
  end

  assign sec     = sec_q;
  assign min     = min_q;
  assign state   = state_q;
  assign running = running_q;
  assign expired = expired_q;
  assign tick    = tick_q;

endmodule

// File: doc/timer_controller.md
TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per one-second tick (minimum 2).
REQ-002 Parameter MIN_MAX, default 99, largest minute value (1..127).
REQ-003 Parameter AUTO_RELOAD, default 0, 1 = on expiry reload the preset and keep counting down.
REQ-004 clk  input  1  system clock; the only clock.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  level button; only its rising edge acts.
REQ-007 stop  input  1  level button; only its rising edge acts.
REQ-008 clear  input  1  level button; only its rising edge acts.
REQ-009 inc_sec  input  1  level button; rising edge increments preset seconds.
REQ-010 inc_min  input  1  level button; rising edge increments preset minutes.
REQ-011 dir  input  1  count direction: 0 = down, 1 = up; sampled on the start edge only.
REQ-012 sec  output  6  displayed seconds, 0..59.
REQ-013 min  output  7  displayed minutes, 0..MIN_MAX.
REQ-014 state  output  3  current state code.
REQ-015 running  output  1  high while in RUN.
REQ-016 expired  output  1  high while in EXPIRED.
REQ-017 tick  output  1  one-cycle pulse on each counted second in RUN.

Function
REQ-018 Five states SHALL be implemented, with these codes: IDLE=0, SET=1, RUN=2, PAUSE=3, EXPIRED=4; any other code SHALL return to IDLE on the next clock.
REQ-019 Each button SHALL be edge-detected against its value registered on the previous clock; one edge SHALL produce exactly one action.
REQ-020 When several edges occur in the same cycle, only the highest-priority one SHALL act: clear > stop > start > inc_min > inc_sec.
REQ-021 IDLE: sec=min=0, preset=0; inc_sec/inc_min edge -> SET and apply that increment; start edge -> RUN.
REQ-022 SET: an inc_sec edge SHALL add 1 to preset seconds, wrapping 59->0 without carry into minutes.
REQ-023 SET: an inc_min edge SHALL add 1 to preset minutes, wrapping MIN_MAX->0.
REQ-024 SET: sec/min SHALL display the preset; start edge -> RUN; clear edge -> IDLE.
REQ-025 RUN entry: the direction SHALL latch dir; down loads the preset, up loads 00:00; the prescaler SHALL clear to 0.
REQ-026 RUN: the prescaler SHALL count 0..TICK_DIV-1; at TICK_DIV-1, tick SHALL pulse and the time SHALL update on that same edge.
REQ-027 Up-count: sec 59->0 SHALL carry to min; at MIN_MAX:59 the next tick SHALL hold the value and enter EXPIRED.
REQ-028 Down-count: sec 0->59 SHALL borrow from min; the tick that reaches 00:00 SHALL enter EXPIRED on that same edge.
REQ-029 RUN with down-count and preset 00:00 SHALL enter EXPIRED on the clock after entry, without waiting for a tick.
REQ-030 RUN: stop edge -> PAUSE; clear edge -> IDLE.
REQ-031 PAUSE: time and prescaler SHALL freeze; start edge -> RUN resuming without reload, prescaler and direction kept; clear edge -> IDLE.
REQ-032 EXPIRED with AUTO_RELOAD=0: time SHALL hold; clear or stop edge -> IDLE.
REQ-033 EXPIRED with AUTO_RELOAD=1 and direction down: the next clock SHALL reload the preset and return to RUN.
REQ-034 The preset SHALL be retained through RUN, PAUSE and EXPIRED, and cleared only in IDLE.
REQ-035 running and expired SHALL be decoded from registered state with no combinational input paths; tick SHALL be registered.
REQ-036 IDLE, SET, PAUSE: tick SHALL be 0.

Reset
REQ-037 When rst_n=0 asynchronously: state=IDLE, sec=0, min=0, preset=0, prescaler=0, running=0, expired=0, tick=0.
REQ-038 When rst_n=0: the edge-detect registers SHALL load 1, so a button held through reset release does not act.
REQ-039 Reset asserted mid-RUN SHALL abort the count without any further tick.

Verification (TICK_DIV=4, MIN_MAX=99)
REQ-040 Up-count: start edge from IDLE with dir=1 -> RUN; tick every 4 cycles; 00:01 after 4 cycles; 01:00 after 240 cycles.
REQ-041 Set then count down: 3x inc_sec, 1x inc_min -> SET showing 01:03; start edge with dir=0 -> counts down to 00:00 after 63 ticks; expired=1; time held.
REQ-042 Wrap: 60 inc_sec edges -> seconds back to 0 with min unchanged; 100 inc_min edges -> minutes back to 0.
REQ-043 Pause: stop edge at 00:05 mid-prescale -> value frozen for 20 cycles; start edge -> resumes with the residual prescale.
REQ-044 Priority and edges: clear, stop and start rising in the same cycle -> IDLE; start held high for 50 cycles -> exactly one action; start held through reset release -> no action.
REQ-045 AUTO_RELOAD=1 with preset 00:02 down -> EXPIRED for exactly 1 cycle, then RUN at 00:02, repeating.
